// File: rtl/dma_arb_pkg.sv
// Shared types and sizing helpers for the DMA register-port arbiters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  localparam int NUM_REQ_DFLT = 4;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = (NUM_REQ_DFLT > 1) ? $clog2(NUM_REQ_DFLT) : 1;

  typedef logic [ID_W-1:0] gnt_id_t;

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin search: first valid index at or after ptr, wrapping.
module dma_rr_picker
  import dma_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = id_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  int unsigned idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!gnt_any && valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_oh[idx]  = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dma_reg_arbiter.sv
// Round-robin sharing of the single DMA register-file port between NUM_REQ
// requesters: handshake in IDLE, strobe in ISSUE, response pulse in RESP.
module dma_reg_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int ADDR_WIDTH = `ADDR_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          wr_en,
  output logic                          rd_en,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic [DATA_WIDTH-1:0]         wdata,
  input  logic [DATA_WIDTH-1:0]         rdata,
  output logic                          busy
);

  localparam int IW = id_width(NUM_REQ);

  arb_state_e           state, state_nxt;
  logic [IW-1:0]        ptr, gnt;
  logic                 gnt_write;
  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 hs;

  dma_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .valid   (req_valid),
    .ptr     (ptr),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign hs = (state == IDLE) && pick_any;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are set on the handshake edge so they are high exactly in ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_write <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
    end else begin
      state <= state_nxt;
      wr_en <= 1'b0;
      rd_en <= 1'b0;
      if (hs) begin
        gnt       <= pick_idx;
        gnt_write <= req_write[pick_idx];
        addr      <= req_addr[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        wdata     <= req_wdata[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
        wr_en     <= req_write[pick_idx];
        rd_en     <= !req_write[pick_idx];
      end
      if (state == RESP)
        ptr <= (gnt == IW'(NUM_REQ-1)) ? '0 : gnt + IW'(1);
    end
  end

  // state already reads IDLE during reset, so ready needs the explicit gate.
  assign req_ready = (state == IDLE && !rst) ? pick_oh : '0;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      rsp_valid[i] = (state == RESP) && (gnt == IW'(i));
  end

  assign rsp_rdata = (state == RESP && !gnt_write) ? rdata : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dma_reg_arbiter.sv
// Scoreboard bench: handshakes push expected strobe/response records that the
// negedge monitor pops and compares against the register port and responses.
module tb_dma_reg_arbiter;
  import dma_arb_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, wdata, rdata;
  logic [AW-1:0]   addr;
  logic            wr_en, rd_en, busy;

  always #5 clk = ~clk;

  dma_reg_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy)
  );

  // Register file model on the shared port.
  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];
  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

  typedef struct {
    int            id;
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t stq[$];
  txn_t rsq[$];
  int   gnt_log[$];
  int   cyc_log[$];
  int   cyc = 0;
  int   phase = 0;
  int   tb_ptr = 0;
  int   n_hs = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr(input logic [N-1:0] v, input int p);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (r == '0 && v[(p + i) % N]) r[(p + i) % N] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  txn_t         mt;
  logic [N-1:0] exp_rdy;
  int           mid;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_strobes", {wr_en, rd_en, busy}, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_rdata}, 0);
      chk("rst_port", {addr, wdata}, 0);
      stq.delete();
      rsq.delete();
      phase  = 0;
      tb_ptr = 0;
    end else begin
      exp_rdy = (phase == 0) ? rr(req_valid, tb_ptr) : '0;
      chk("req_ready", req_ready, exp_rdy);
      chk("busy", busy, phase != 0);
      chk("strobe_excl", wr_en & rd_en, 0);
      case (phase)
        0: begin
          chk("idle_strobe", wr_en | rd_en, 0);
          chk("idle_rsp", rsp_valid, 0);
          if (exp_rdy != '0) begin
            mid = 0;
            for (int i = 0; i < N; i++) if (exp_rdy[i]) mid = i;
            mt.id = mid;
            mt.wr = req_write[mid];
            mt.a  = req_addr[mid*AW +: AW];
            mt.d  = req_wdata[mid*DW +: DW];
            mt.rd = mt.wr ? '0 : shadow[mt.a];
            if (mt.wr) shadow[mt.a] = mt.d;
            stq.push_back(mt);
            rsq.push_back(mt);
            gnt_log.push_back(mid);
            cyc_log.push_back(cyc);
            n_hs++;
            phase = 1;
          end
        end
        1: begin
          chk("strobe_q", stq.size(), 1);
          if (stq.size() > 0) begin
            mt = stq.pop_front();
            chk("wr_en", wr_en, mt.wr);
            chk("rd_en", rd_en, !mt.wr);
            chk("addr", addr, mt.a);
            if (mt.wr) chk("wdata", wdata, mt.d);
          end
          chk("issue_rsp", rsp_valid, 0);
          phase = 2;
        end
        default: begin
          chk("rsp_q", rsq.size(), 1);
          chk("resp_strobe", wr_en | rd_en, 0);
          if (rsq.size() > 0) begin
            mt = rsq.pop_front();
            chk("rsp_valid", rsp_valid, 1 << mt.id);
            chk("rsp_rdata", rsp_rdata, mt.rd);
            tb_ptr = (mt.id + 1) % N;
          end
          phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_one(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i]         = 1'b1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[i]) break;
    end
    chk("hs_timeout", k < 20, 1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  // Hold a set of reads until each one is accepted.
  task automatic hold_until_granted(input logic [N-1:0] set);
    logic [N-1:0] g;
    int k;
    req_write = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(32 + i);
    req_valid = set;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      tick();
      req_valid = req_valid & ~g;
      if (req_valid == '0) break;
    end
    chk("hold_timeout", k < 30, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    rdata = '0;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single write then read-back through another requester.
    req_one(0, 1'b1, 8'h04, 32'hDEADBEEF);
    repeat (2) tick();
    req_one(2, 1'b0, 8'h04, '0);
    repeat (2) tick();
    chk("readback_mem", mem[4], 32'hDEADBEEF);

    // Fairness from a fresh reset with every requester continuously valid.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gnt_log.delete(); cyc_log.delete();
    req_write = '0;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i);
    req_valid = '1;
    repeat (16) tick();
    req_valid = '0;
    repeat (4) tick();
    chk("fair_count", gnt_log.size() >= 5, 1);
    if (gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("fair_gnt%0d", i), gnt_log[i], i % N);
      for (int i = 1; i < 5; i++) chk($sformatf("fair_gap%0d", i), cyc_log[i] - cyc_log[i-1], 3);
    end

    // Wrap: after req1, requesters 3 and 0 compete; 3 wins first.
    req_one(1, 1'b0, 8'h04, '0);
    repeat (2) tick();
    gnt_log.delete();
    hold_until_granted(4'b1001);
    repeat (3) tick();
    chk("wrap_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      chk("wrap_first", gnt_log[0], 3);
      chk("wrap_second", gnt_log[1], 0);
    end

    // Reset while a read is in ISSUE: strobe drops at once, no response.
    req_one(0, 1'b0, 8'h08, '0);
    chk("issue_rd_en", rd_en, 1);
    rst = 1'b1;
    #1;
    chk("async_rd_en", rd_en, 0);
    chk("async_busy", busy, 0);
    chk("async_rsp", rsp_valid, 0);
    chk("async_addr", addr, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    gnt_log.delete();
    hold_until_granted(4'b1010);
    repeat (3) tick();
    chk("post_rst_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) chk("post_rst_first", gnt_log[0], 1);

    // Request pulsed only during RESP must not be accepted.
    req_one(0, 1'b1, 8'h10, 32'h0000_1234);
    tick();
    chk("in_resp", busy, 1);
    mid = n_hs;
    req_write[2] = 1'b1;
    req_addr[2*AW +: AW] = 8'h20;
    req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    repeat (4) tick();
    chk("withdrawn_hs", n_hs, mid);
    chk("withdrawn_mem", mem[8'h20], 0);

    req_one(3, 1'b0, 8'h10, '0);
    repeat (3) tick();
    chk("final_q", stq.size() + rsq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
